// File: rtl/uds_pkg.sv
// ---------------------------------------------------------------------------
// uds_pkg
// Shared definitions for the UDS row feeder and its sub-blocks.
//   UDS_DW          : default element width in bits
//   feeder_state_e  : row feeder FSM states
//   SCALE_DS2_MAX   : scale_factor encoding for downsample-by-2 (max)
//   MODE_DS2_MAX    : function_mode encoding for downsample-by-2 (max)
// ---------------------------------------------------------------------------
package uds_pkg;

  localparam int UDS_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL0,
    FILL1,
    ISSUE0,
    ISSUE1,
    GAP
  } feeder_state_e;

  // Encoding 0 of both fields selects downsample-by-2 (max) in UDS; this is
  // also what the feeder presents out of reset.
  localparam logic [1:0] SCALE_DS2_MAX = 2'd0;
  localparam logic [1:0] MODE_DS2_MAX  = 2'd0;

endpackage

// File: rtl/uds_row_assembler.sv
// ---------------------------------------------------------------------------
// uds_row_assembler
// Collects A/W consecutive beats of W elements into one A-element row.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart the beat counter at slot 0 (row data untouched)
//   wr_en      : write the current beat into the slot the counter points at
//   beat       : W elements, element j in bits [j*DW +: DW]
//   row        : assembled row, element i in bits [i*DW +: DW]
//   last_beat  : counter sits on the final slot, so a write now fills the row
// ---------------------------------------------------------------------------
module uds_row_assembler #(
  parameter int A  = 64,
  parameter int W  = 8,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [W*DW-1:0] beat,
  output logic [A*DW-1:0] row,
  output logic            last_beat
);

  localparam int BEATS = A / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0] beat_cnt;

  assign last_beat = (beat_cnt == CW'(BEATS - 1));

  // The counter wraps to 0 on the final beat, so the next row starts at slot 0
  // without the FSM having to issue a separate clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      row      <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (wr_en) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      for (int k = 0; k < BEATS; k++) begin
        if (beat_cnt == CW'(k)) begin
          row[k*W*DW +: W*DW] <= beat;
        end
      end
    end
  end

endmodule

// File: rtl/uds_row_feeder.sv
// ---------------------------------------------------------------------------
// uds_row_feeder
// Assembles narrow pixel beats into A-element rows and issues them to UDS in
// pairs (row0 with active=0, row1 with active=1, then one idle cycle).
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : job start, honoured only while idle
//   num_pairs                : row pairs in the job, sampled on start
//   scale_factor_in          : UDS scale factor, sampled on start
//   function_mode_in         : UDS function mode, sampled on start
//   in_data/in_valid/in_ready: beat stream, element j in [j*DW +: DW]
//   idata/idata_valid/active : row stream to UDS, element i in [i*DW +: DW]
//   scale_factor/function_mode: configuration held for UDS
//   busy                     : job in progress
//   done                     : one-cycle pulse at job end
// ---------------------------------------------------------------------------
module uds_row_feeder
  import uds_pkg::*;
#(
  parameter int A   = 64,
  parameter int W   = 8,
  parameter int DW  = UDS_DW,
  parameter int PCW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PCW-1:0]  num_pairs,
  input  logic [1:0]      scale_factor_in,
  input  logic [1:0]      function_mode_in,
  input  logic [W*DW-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [A*DW-1:0] idata,
  output logic            idata_valid,
  output logic            active,
  output logic [1:0]      scale_factor,
  output logic [1:0]      function_mode,
  output logic            busy,
  output logic            done
);

  feeder_state_e state, state_n;

  logic [PCW-1:0]  num_pairs_q;
  logic [PCW-1:0]  pair_cnt;
  logic [PCW-1:0]  pair_inc;
  logic            last_pair;
  logic            accept;
  logic            job_start;
  logic            wr0, wr1;
  logic            last0, last1;
  logic [A*DW-1:0] row0, row1;

  // in_ready is a registered decode of the state, so accept never depends
  // combinationally on anything but in_valid and flops.
  assign accept    = in_valid & in_ready;
  assign job_start = (state == IDLE) & start;
  assign wr0       = accept & (state == FILL0);
  assign wr1       = accept & (state == FILL1);

  // Exact PCW-bit equality on the incremented count: the count never needs to
  // exceed num_pairs, so the all-ones job length completes without wrapping.
  assign pair_inc  = pair_cnt + 1'b1;
  assign last_pair = (pair_inc == num_pairs_q);

  uds_row_assembler #(.A(A), .W(W), .DW(DW)) u_row0 (
    .clk       (clk),
    .rst       (rst),
    .clear     (job_start),
    .wr_en     (wr0),
    .beat      (in_data),
    .row       (row0),
    .last_beat (last0)
  );

  uds_row_assembler #(.A(A), .W(W), .DW(DW)) u_row1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (job_start),
    .wr_en     (wr1),
    .beat      (in_data),
    .row       (row1),
    .last_beat (last1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start && (num_pairs != '0)) state_n = FILL0;
      FILL0:   if (wr0 && last0) state_n = FILL1;
      FILL1:   if (wr1 && last1) state_n = ISSUE0;
      ISSUE0:  state_n = ISSUE1;
      ISSUE1:  state_n = GAP;
      GAP:     state_n = last_pair ? IDLE : FILL0;
      default: state_n = IDLE;
    endcase
  end

  // Configuration follows every accepted start, even a zero-pair one, and is
  // then held until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale_factor  <= SCALE_DS2_MAX;
      function_mode <= MODE_DS2_MAX;
      num_pairs_q   <= '0;
      pair_cnt      <= '0;
    end else if (job_start) begin
      scale_factor  <= scale_factor_in;
      function_mode <= function_mode_in;
      if (num_pairs != '0) begin
        num_pairs_q <= num_pairs;
        pair_cnt    <= '0;
      end
    end else if (state == GAP) begin
      pair_cnt <= pair_inc;
    end
  end

  // Row outputs trail the state by one cycle, so ISSUE0 data shows up the
  // cycle after the state is entered and the GAP idle cycle coincides with
  // done. busy and in_ready are taken from the next state so they line up
  // with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      idata_valid <= 1'b0;
      active      <= 1'b0;
      idata       <= '0;
    end else begin
      in_ready    <= (state_n == FILL0) || (state_n == FILL1);
      busy        <= (state_n != IDLE);
      done        <= (job_start && (num_pairs == '0)) || ((state == GAP) && last_pair);
      idata_valid <= (state == ISSUE0) || (state == ISSUE1);
      active      <= (state == ISSUE1);
      if (state == ISSUE0) begin
        idata <= row0;
      end else if (state == ISSUE1) begin
        idata <= row1;
      end else begin
        idata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uds_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_uds_row_feeder
// Randomised scoreboard bench for uds_row_feeder. Each job builds its element
// stream up front; the expected rows are consecutive A-element slices of that
// stream, alternating active=0/1. A negedge monitor pops and compares rows,
// done, cfg and reset values independently of the stimulus process.
// ---------------------------------------------------------------------------
module tb_uds_row_feeder;

  localparam int A     = 64;
  localparam int W     = 8;
  localparam int DW    = 32;
  localparam int PCW   = 16;
  localparam int BEATS = A / W;

  typedef struct {
    logic [A*DW-1:0] data;
    bit              act;
    bit              last;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [PCW-1:0]  num_pairs;
  logic [1:0]      scale_factor_in;
  logic [1:0]      function_mode_in;
  logic [W*DW-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [A*DW-1:0] idata;
  logic            idata_valid;
  logic            active;
  logic [1:0]      scale_factor;
  logic [1:0]      function_mode;
  logic            busy;
  logic            done;

  exp_t            exp_q[$];
  logic [W*DW-1:0] beat_q[$];
  int              acc_q[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   zero_done_cyc = -1;
  bit   expect_done_next = 0;
  bit   prev_act = 0;
  logic [1:0] exp_sf = 2'd0;
  logic [1:0] exp_fm = 2'd0;
  exp_t mon_e;

  uds_row_feeder #(.A(A), .W(W), .DW(DW), .PCW(PCW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_pairs        (num_pairs),
    .scale_factor_in  (scale_factor_in),
    .function_mode_in (function_mode_in),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .idata            (idata),
    .idata_valid      (idata_valid),
    .active           (active),
    .scale_factor     (scale_factor),
    .function_mode    (function_mode),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkRow(input string name, input logic [A*DW-1:0] act, input logic [A*DW-1:0] exp);
    bit reported;
    reported = 0;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      for (int i = 0; i < A; i++) begin
        if (!reported && (act[i*DW +: DW] !== exp[i*DW +: DW])) begin
          $display("[TB] FAIL %s element %0d: got %h expected %h (cycle %0d)",
                   name, i, act[i*DW +: DW], exp[i*DW +: DW], cyc);
          reported = 1;
        end
      end
    end
  endtask

  // Monitor: compares everything the DUT presents on each falling edge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("reset_outputs",
                  32'({in_ready, idata_valid, active, busy, done, scale_factor, function_mode, |idata}),
                  32'd0);
      prev_act = 0;
    end else begin
      checkOutput("done", 32'(done), 32'(expect_done_next || (cyc == zero_done_cyc)));
      if (done) done_cnt++;
      if (expect_done_next) checkOutput("busy_at_done", 32'(busy), 32'd0);
      expect_done_next = 0;
      if (prev_act) checkOutput("gap_after_pair", 32'(idata_valid), 32'd0);
      checkOutput("scale_factor", 32'(scale_factor), 32'(exp_sf));
      checkOutput("function_mode", 32'(function_mode), 32'(exp_fm));
      if (idata_valid) begin
        checkOutput("in_ready_during_issue", 32'(in_ready), 32'd0);
        checkOutput("busy_during_issue", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_row: got a valid row, expected none (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkRow("row_data", idata, mon_e.data);
          checkOutput("row_active", 32'(active), 32'(mon_e.act));
          if (!mon_e.act) begin
            if (acc_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("[TB] FAIL issue_latency: row0 issued with no completed pair (cycle %0d)", cyc);
            end else begin
              checkOutput("issue_latency", 32'(cyc), 32'(acc_q.pop_front() + 2));
            end
          end
          if (mon_e.act && mon_e.last) expect_done_next = 1;
        end
      end else begin
        checkOutput("idle_idata_zero", 32'({active, |idata}), 32'd0);
      end
      prev_act = idata_valid && active;
    end
  end

  // Builds the job's element stream, queues the expected rows and pulses start.
  task automatic applyStimulus(input int np, input logic [1:0] sf, input logic [1:0] fm, input bit pattern);
    exp_t            e;
    logic [W*DW-1:0] beat;
    logic [DW-1:0]   elem;
    beat_q.delete();
    for (int r = 0; r < 2 * np; r++) begin
      e.data = '0;
      e.act  = (r % 2) == 1;
      e.last = (r == 2 * np - 1);
      for (int k = 0; k < BEATS; k++) begin
        beat = '0;
        for (int j = 0; j < W; j++) begin
          elem = pattern ? DW'(r * A + k * W + j) : DW'($urandom);
          beat[j*DW +: DW] = elem;
          e.data[(k*W + j)*DW +: DW] = elem;
        end
        beat_q.push_back(beat);
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    start            = 1'b1;
    num_pairs        = PCW'(np);
    scale_factor_in  = sf;
    function_mode_in = fm;
    @(posedge clk);
    #1;
    start  = 1'b0;
    exp_sf = sf;
    exp_fm = fm;
    if (np == 0) zero_done_cyc = cyc;
    exp_done++;
  endtask

  // Offers beats [first, first+count) with pct% valid probability, holding an
  // offered beat until it is taken.
  task automatic feedBeats(input int first, input int count, input int pct);
    int  i;
    int  guard;
    bit  acc;
    int  c;
    i     = first;
    guard = 0;
    while ((i < first + count) && (guard < 4000)) begin
      @(negedge clk);
      if (!in_valid) begin
        if ($urandom_range(99) < pct) begin
          in_valid = 1'b1;
          in_data  = beat_q[i];
        end else begin
          in_data  = {W{DW'($urandom)}};
        end
      end
      acc = in_valid && in_ready;
      c   = cyc;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        if ((i % (2 * BEATS)) == 2 * BEATS - 1) acc_q.push_back(c);
        in_valid = 1'b0;
        i++;
      end
    end
    in_valid = 1'b0;
    if (i < first + count) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL beat_feed_timeout: accepted %0d beats, expected %0d", i - first, count);
    end
  endtask

  task automatic waitDone();
    int guard;
    guard = 0;
    while ((done_cnt < exp_done) && (guard < 3000)) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    checkOutput("done_count", 32'(done_cnt), 32'(exp_done));
    checkOutput("rows_left", 32'(exp_q.size()), 32'd0);
    checkOutput("pairs_left", 32'(acc_q.size()), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    start            = 1'b0;
    num_pairs        = '0;
    scale_factor_in  = 2'd0;
    function_mode_in = 2'd0;
    in_data          = '0;
    in_valid         = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] single pair, gapless, element = row*64+index");
    applyStimulus(1, 2'd0, 2'd0, 1'b1);
    feedBeats(0, 2 * BEATS, 100);
    waitDone();

    $display("[TB] three pairs, 50%% valid, cfg 2/1");
    applyStimulus(3, 2'd2, 2'd1, 1'b0);
    feedBeats(0, 6 * BEATS, 50);
    waitDone();

    $display("[TB] zero-pair job");
    applyStimulus(0, 2'd1, 2'd3, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("zero_job_in_ready", 32'(in_ready), 32'd0);
      checkOutput("zero_job_busy", 32'(busy), 32'd0);
    end
    waitDone();

    $display("[TB] start re-pulsed mid-job");
    applyStimulus(2, 2'd1, 2'd2, 1'b0);
    fork
      feedBeats(0, 4 * BEATS, 70);
      begin
        repeat (6) @(negedge clk);
        start           = 1'b1;
        num_pairs       = PCW'(5);
        scale_factor_in = 2'd3;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    waitDone();

    $display("[TB] reset after 10 beats of pair 2");
    applyStimulus(2, 2'd3, 2'd1, 1'b0);
    feedBeats(0, 2 * BEATS + 10, 100);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    expect_done_next = 0;
    exp_sf = 2'd0;
    exp_fm = 2'd0;
    exp_done--;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1, 2'd2, 2'd2, 1'b0);
    feedBeats(0, 2 * BEATS, 60);
    waitDone();

    $display("[TB] gapless two pairs, beat held across issue");
    applyStimulus(2, 2'd1, 2'd1, 1'b0);
    feedBeats(0, 4 * BEATS, 100);
    waitDone();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
